// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer that drives an external registered 1-bit ALU slice LSB first.
// Latency: start accepted on edge E0, result/done registered on edge E(WIDTH+1).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       func,
    output logic             s_inA,
    output logic             s_inB,
    output logic             s_Cin,
    output logic             s_binv,
    output logic             s_less,
    output logic [1:0]       s_op,
    input  logic             s_result,
    input  logic             s_Cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    // Function encodings accepted on the func input.
    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_SLTU = 3'b011;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLT  = 3'b111;

    // Slice operation encodings.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       func_q;
    // Result bits 0..WIDTH-2; the MSB arrives straight from the slice in DRAIN.
    logic [WIDTH-2:0] res_sh;
    // Carry into the MSB, kept for the overflow calculation in DRAIN.
    logic             cin_msb;

    logic             k_first;
    logic             k_last;
    logic [WIDTH-1:0] final_res;
    logic             final_ovf;

    assign k_first = (k == '0);
    assign k_last  = (k == K_LAST);
    assign busy    = (state != IDLE);

    // State register: reset wins over everything, including start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-bit slice drive; the slice sees all zeros outside RUN.
    always_comb begin
        state_nxt = state;
        s_inA     = 1'b0;
        s_inB     = 1'b0;
        s_Cin     = 1'b0;
        s_binv    = 1'b0;
        s_less    = 1'b0;
        s_op      = OP_AND;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (k_last) begin
                    state_nxt = DRAIN;
                end
                s_inA = a_q[k];
                s_inB = b_q[k];
                case (func_q)
                    F_AND: s_op = OP_AND;
                    F_OR:  s_op = OP_OR;
                    F_ADD: begin
                        // Bit 0 uses a fixed carry so a stale slice carry never leaks in.
                        s_op  = OP_ADD;
                        s_Cin = k_first ? 1'b0 : s_Cout;
                    end
                    F_SUB: begin
                        // Two's complement: invert b and inject +1 at bit 0.
                        s_op   = OP_ADD;
                        s_binv = 1'b1;
                        s_Cin  = k_first ? 1'b1 : s_Cout;
                    end
                    F_SLTU: begin
                        s_op   = OP_CMP;
                        s_less = k_first ? 1'b0 : s_result;
                    end
                    F_SLT: begin
                        // Swapping the sign bits turns the unsigned compare into a signed one.
                        s_op   = OP_CMP;
                        s_less = k_first ? 1'b0 : s_result;
                        if (k_last) begin
                            s_inA = b_q[WIDTH-1];
                            s_inB = a_q[WIDTH-1];
                        end
                    end
                    default: s_op = OP_AND;
                endcase
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Assemble the final result from the captured bits and the MSB now on the slice output.
    always_comb begin
        final_res = '0;
        final_ovf = 1'b0;
        case (func_q)
            F_AND, F_OR: begin
                final_res = {s_result, res_sh};
            end
            F_ADD, F_SUB: begin
                final_res = {s_result, res_sh};
                final_ovf = cin_msb ^ s_Cout;
            end
            F_SLT, F_SLTU: begin
                final_res = {{(WIDTH-1){1'b0}}, s_result};
            end
            default: begin
                final_res = '0;
                final_ovf = 1'b0;
            end
        endcase
    end

    // Operand latch, bit counter, result capture and the registered completion outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            k        <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= F_AND;
            res_sh   <= '0;
            cin_msb  <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        func_q <= func;
                        k      <= '0;
                    end
                end
                RUN: begin
                    // Slice output now reflects bit k-1 driven in the previous cycle.
                    if (!k_first) begin
                        res_sh[k - 1'b1] <= s_result;
                    end
                    if (k_last) begin
                        cin_msb <= s_Cin;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    done     <= 1'b1;
                    result   <= final_res;
                    overflow <= final_ovf;
                    zero     <= (final_res == '0);
                    k        <= '0;
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural model of the registered 1-bit slice.
// Checks reset state, arithmetic/logic/compare results, latency, abort and back-to-back starts.
// Slice outputs start at 1 so stale carry/compare values would corrupt a faulty bit-0 path.
module tb_alu_serial_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] func;
    logic       s_inA, s_inB, s_Cin, s_binv, s_less;
    logic [1:0] s_op;
    logic       sl_res  = 1'b1;
    logic       sl_cout = 1'b1;
    logic       busy, done, overflow, zero;
    logic [7:0] result;
    wire        sl_bb = s_inB ^ s_binv;

    int checks   = 0;
    int failures = 0;

    int   nd, first_d, last_d;
    logic gap_ok, res_ok;

    always #5 clock = ~clock;

    alu_serial_seq #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .func     (func),
        .s_inA    (s_inA),
        .s_inB    (s_inB),
        .s_Cin    (s_Cin),
        .s_binv   (s_binv),
        .s_less   (s_less),
        .s_op     (s_op),
        .s_result (sl_res),
        .s_Cout   (sl_cout),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    // Registered 1-bit ALU slice; compare result is 1 when a<b decided at this bit, else less.
    always @(posedge clock) begin
        case (s_op)
            2'b00: begin sl_res <= s_inA & sl_bb; sl_cout <= 1'b1; end
            2'b01: begin sl_res <= s_inA | sl_bb; sl_cout <= 1'b1; end
            2'b10: begin
                sl_res  <= s_inA ^ sl_bb ^ s_Cin;
                sl_cout <= (s_inA & sl_bb) | (s_inA & s_Cin) | (sl_bb & s_Cin);
            end
            default: begin
                sl_res  <= (s_inA != sl_bb) ? sl_bb : s_less;
                sl_cout <= 1'b1;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [7:0] va,
                          input logic [7:0] vb, input bit noise, input logic [7:0] er,
                          input logic eo, input logic ez);
        int         lat;
        int         cnt;
        logic       bok;
        logic       rbusy;
        logic [7:0] rres;
        logic       rov, rz;
        lat   = -1;
        cnt   = 0;
        bok   = 1'b1;
        rbusy = 1'bx;
        rres  = 'x;
        rov   = 1'bx;
        rz    = 1'bx;
        @(negedge clock);
        start = 1'b1; func = f; a = va; b = vb;
        @(negedge clock);
        // Operands change after acceptance; the DUT must use the latched copies.
        start = 1'b0; a = ~va; b = ~vb; func = ~f;
        check({tag, ":busy_after_accept"}, busy, 1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (done) begin
                cnt++;
                if (lat < 0) begin
                    lat = c; rres = result; rov = overflow; rz = zero; rbusy = busy;
                end
            end else if (lat < 0 && !busy) begin
                bok = 1'b0;
            end
            start = noise && (c <= 6);
        end
        check({tag, ":latency"}, lat, 9);
        check({tag, ":done_count"}, cnt, 1);
        check({tag, ":busy_while_running"}, bok, 1);
        check({tag, ":busy_in_done_cycle"}, rbusy, 0);
        check({tag, ":result"}, rres, er);
        check({tag, ":overflow"}, rov, eo);
        check({tag, ":zero"}, rz, ez);
        check({tag, ":result_held"}, result, er);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; func = '0;
        repeat (3) @(negedge clock);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:result", result, 0);
        check("reset:overflow", overflow, 0);
        check("reset:zero", zero, 0);
        check("reset:s_op", s_op, 0);
        check("reset:drives", {s_inA, s_inB, s_Cin, s_binv, s_less}, 0);
        reset = 1'b0;

        run_op("add_7f_01",  3'b010, 8'h7F, 8'h01, 0, 8'h80, 1'b1, 1'b0);
        run_op("add_ff_01",  3'b010, 8'hFF, 8'h01, 0, 8'h00, 1'b0, 1'b1);
        run_op("sub_05_05",  3'b110, 8'h05, 8'h05, 0, 8'h00, 1'b0, 1'b1);
        run_op("sub_80_01",  3'b110, 8'h80, 8'h01, 0, 8'h7F, 1'b1, 1'b0);
        run_op("slt_ff_01",  3'b111, 8'hFF, 8'h01, 0, 8'h01, 1'b0, 1'b0);
        run_op("sltu_ff_01", 3'b011, 8'hFF, 8'h01, 0, 8'h00, 1'b0, 1'b1);
        run_op("slt_42_42",  3'b111, 8'h42, 8'h42, 0, 8'h00, 1'b0, 1'b1);
        run_op("slt_01_ff",  3'b111, 8'h01, 8'hFF, 0, 8'h00, 1'b0, 1'b1);
        run_op("sltu_01_ff", 3'b011, 8'h01, 8'hFF, 0, 8'h01, 1'b0, 1'b0);
        run_op("unsup_100",  3'b100, 8'hFF, 8'hFF, 0, 8'h00, 1'b0, 1'b1);
        run_op("and_f0_3c",  3'b000, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0);
        run_op("or_f0_3c",   3'b001, 8'hF0, 8'h3C, 1, 8'hFC, 1'b0, 1'b0);

        // Abort an ADD at bit 3; reset must also win over a simultaneous start.
        @(negedge clock);
        start = 1'b1; func = 3'b010; a = 8'h33; b = 8'h44;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort:busy", busy, 0);
        check("abort:done", done, 0);
        check("abort:result", result, 0);
        check("abort:overflow", overflow, 0);
        start = 1'b1;
        @(negedge clock);
        check("reset_vs_start:busy", busy, 0);
        reset = 1'b0; start = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("abort:no_done", nd, 0);
        run_op("add_01_02", 3'b010, 8'h01, 8'h02, 0, 8'h03, 1'b0, 1'b0);

        // Start held high: each done cycle must accept the next operation.
        @(negedge clock);
        start = 1'b1; func = 3'b010; a = 8'h10; b = 8'h20;
        nd = 0; first_d = -1; last_d = -1; gap_ok = 1'b1; res_ok = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (done) begin
                if (last_d >= 0 && (c - last_d) != 10) gap_ok = 1'b0;
                if (first_d < 0) first_d = c;
                last_d = c;
                nd++;
                if (result !== 8'h30) res_ok = 1'b0;
            end
            if (c == 30) start = 1'b0;
        end
        check("b2b:first_done", first_d, 10);
        check("b2b:done_count", nd, 3);
        check("b2b:spacing", gap_ok, 1);
        check("b2b:results", res_ok, 1);
        @(negedge clock);
        check("b2b:idle_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a, b  input  WIDTH each  operands, latched on start acceptance.
REQ-006 func  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 SLTU; latched with operands.
REQ-007 s_inA, s_inB, s_Cin, s_binv, s_less  output  1 each  per-bit drive to the registered 1-bit ALU slice.
REQ-008 s_op  output  2  slice op: 00 AND, 01 OR, 10 ADD, 11 compare.
REQ-009 s_result, s_Cout  input  1 each  slice outputs, registered inside the slice (valid one clock after its inputs).
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle pulse when result is final.
REQ-012 result  output  WIDTH  final result, held until next completion or reset.
REQ-013 overflow, zero  output  1 each  signed overflow (ADD/SUB only), result==0.

Function
REQ-014 States SHALL be IDLE, RUN, DRAIN; bit counter k counts 0..WIDTH-1 in RUN.
REQ-015 IDLE + start=1: latch a, b, func; k<=0; go RUN; start in RUN/DRAIN SHALL be ignored.
REQ-016 RUN at count k: drive s_inA=a[k], s_inB=b[k]; k=WIDTH-1 -> DRAIN next, else k<=k+1.
REQ-017 AND/OR: s_op=00/01, s_binv=0, s_Cin=0, s_less=0.
REQ-018 ADD/SUB: s_op=10; s_binv=0 (ADD) / 1 (SUB); s_Cin = ADD?0:1 when k=0, else s_Cin=s_Cout (combinational feedback of slice carry from bit k-1).
REQ-019 SLT/SLTU: s_op=11, s_binv=0; s_less=0 at k=0, else s_less=s_result (previous bit's compare); SLT only, at k=WIDTH-1: s_inA=b[MSB], s_inB=a[MSB] (swap for sign).
REQ-020 Capture: in RUN with k>=1 and in DRAIN, s_result SHALL be shifted in as result bit k-1 (DRAIN: bit WIDTH-1); for SLT/SLTU final result = {WIDTH-1 zeros, s_result sampled in DRAIN}.
REQ-021 overflow = (carry into MSB, i.e. s_Cin at k=WIDTH-1) XOR (s_Cout in DRAIN) for ADD/SUB; 0 otherwise.
REQ-022 DRAIN -> IDLE after one cycle; result, overflow, zero, done=1 registered on that edge.
REQ-023 Latency: start accepted at edge E0 -> done high in cycle following edge E(WIDTH+1); busy high cycles E0..E(WIDTH+1).
REQ-024 done SHALL be high exactly one cycle; start high in that cycle (state IDLE) SHALL be accepted.
REQ-025 Unsupported func (100, 101): run full sequence with AND drive, final result 0, overflow 0, zero 1, done pulses.
REQ-026 In IDLE all slice drive outputs SHALL be 0 (s_op=00).
REQ-027 Stale slice s_Cout/s_result at operation start SHALL NOT affect results (k=0 uses internal Cin/less values).

Reset
REQ-028 reset=1 SHALL force IDLE, k=0, busy=0, done=0, result=0, overflow=0, zero=0, slice drives 0, from any state on the next edge.
REQ-029 Reset mid-operation SHALL abort with no done pulse; slice has no reset and needs none.
REQ-030 reset takes priority over start in the same cycle.

Verification (WIDTH=8)
REQ-031 ADD a=0x7F b=0x01 -> result 0x80, overflow 1, zero 0, done 9 cycles after accept edge.
REQ-032 SUB a=0x05 b=0x05 -> result 0x00, zero 1, overflow 0; SUB a=0x80 b=0x01 -> 0x7F, overflow 1.
REQ-033 SLT a=0xFF b=0x01 -> result 0x01; SLTU same operands -> 0x00; SLT a=b=0x42 -> 0x00.
REQ-034 AND 0xF0,0x3C -> 0x30; OR 0xF0,0x3C -> 0xFC; start pulses during busy ignored (single done).
REQ-035 reset asserted at k=3 of an ADD -> busy 0, done never pulses, result 0; new ADD 0x01+0x02 then yields 0x03.
REQ-036 start held high continuously -> back-to-back operations, each done one cycle, next accept in the done cycle.
